// File: rtl/hack_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : hack_data_memory
// Brief    : Hack CPU data memory (16K RAM, 8K screen, keyboard register)
//            with a valid/ready screen scan-out engine for the display.
// Revision : 1.0 - initial release
// ============================================================================
module hack_data_memory #(
  parameter logic [14:0] SCREEN_BASE = 15'h4000,
  parameter logic [14:0] KBD_ADDR    = 15'h6000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [14:0] addressM,
  input  logic [15:0] outM,
  input  logic        writeM,
  output logic [15:0] inM,
  input  logic [15:0] kbd_code,
  input  logic        kbd_strobe,
  output logic        scan_valid,
  input  logic        scan_ready,
  output logic [15:0] scan_data,
  output logic [12:0] scan_addr,
  output logic        scan_frame_start,
  output logic        addr_fault
);

  localparam int unsigned c_RAM_WORDS    = 16384;
  localparam int unsigned c_SCREEN_WORDS = 8192;

  typedef enum logic [0:0] {
    S_LOAD = 1'b0,
    S_HOLD = 1'b1
  } scan_state_t;

  // Storage arrays carry no reset: their contents survive reset_n.
  logic [15:0] r_ram    [0:c_RAM_WORDS-1];
  logic [15:0] r_screen [0:c_SCREEN_WORDS-1];

  logic [15:0] r_kbd;
  logic        r_addr_fault;

  scan_state_t r_state;
  scan_state_t w_state_next;
  logic [12:0] r_scan_idx;
  logic [15:0] r_scan_data;
  logic [12:0] r_scan_addr;
  logic        r_scan_valid;
  logic        w_load;
  logic        w_xfer;

  // Address decode. The screen window is found by offset from its base so
  // the base can be moved without touching the decode.
  logic [14:0] w_scr_off;
  logic        w_ram_hit;
  logic        w_scr_hit;
  logic        w_kbd_hit;
  logic [15:0] w_in_m;

  assign w_scr_off = addressM - SCREEN_BASE;
  assign w_ram_hit = (addressM < 15'(c_RAM_WORDS));
  assign w_scr_hit = (addressM >= SCREEN_BASE) && (w_scr_off < 15'(c_SCREEN_WORDS));
  assign w_kbd_hit = (addressM == KBD_ADDR);

  // CPU read mux: purely combinational, unmapped space reads as zero.
  always_comb begin
    w_in_m = 16'h0000;
    if (w_ram_hit) begin
      w_in_m = r_ram[addressM[13:0]];
    end else if (w_scr_hit) begin
      w_in_m = r_screen[w_scr_off[12:0]];
    end else if (w_kbd_hit) begin
      w_in_m = r_kbd;
    end
  end

  assign inM = w_in_m;

  // RAM write port.
  always_ff @(posedge clk) begin
    if (writeM && w_ram_hit) begin
      r_ram[addressM[13:0]] <= outM;
    end
  end

  // Screen write port; the scan fetch reads the pre-edge value of the same
  // array, which gives read-before-write on a same-word collision.
  always_ff @(posedge clk) begin
    if (writeM && w_scr_hit) begin
      r_screen[w_scr_off[12:0]] <= outM;
    end
  end

  // Keyboard register and sticky fault for writes outside RAM/screen.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_kbd        <= 16'h0000;
      r_addr_fault <= 1'b0;
    end else begin
      if (kbd_strobe) begin
        r_kbd <= kbd_code;
      end
      if (writeM && !w_ram_hit && !w_scr_hit) begin
        r_addr_fault <= 1'b1;
      end
    end
  end

  // Scan engine next-state logic and per-state strobes.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_xfer       = 1'b0;
    case (r_state)
      S_LOAD: begin
        w_load       = 1'b1;
        w_state_next = S_HOLD;
      end
      S_HOLD: begin
        if (scan_ready) begin
          w_xfer       = 1'b1;
          w_state_next = S_LOAD;
        end
      end
      default: begin
        w_state_next = S_LOAD;
      end
    endcase
  end

  // Scan engine state, index counter and offered-word registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_LOAD;
      r_scan_idx   <= 13'd0;
      r_scan_data  <= 16'h0000;
      r_scan_addr  <= 13'd0;
      r_scan_valid <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_load) begin
        r_scan_data  <= r_screen[r_scan_idx];
        r_scan_addr  <= r_scan_idx;
        r_scan_valid <= 1'b1;
      end
      if (w_xfer) begin
        // 13-bit counter wraps 8191 -> 0 on its own.
        r_scan_valid <= 1'b0;
        r_scan_idx   <= r_scan_idx + 13'd1;
      end
    end
  end

  assign scan_valid       = r_scan_valid;
  assign scan_data        = r_scan_data;
  assign scan_addr        = r_scan_addr;
  assign scan_frame_start = r_scan_valid && (r_scan_addr == 13'd0);
  assign addr_fault       = r_addr_fault;

endmodule
`default_nettype wire

// File: tb/tb_hack_data_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_hack_data_memory
// Brief    : Self-checking bench for hack_data_memory against a word-level
//            model of the address map and the scan stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hack_data_memory;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [14:0] addressM;
  logic [15:0] outM;
  logic        writeM;
  logic [15:0] inM;
  logic [15:0] kbd_code;
  logic        kbd_strobe;
  logic        scan_valid;
  logic        scan_ready;
  logic [15:0] scan_data;
  logic [12:0] scan_addr;
  logic        scan_frame_start;
  logic        addr_fault;

  int checks = 0;
  int errors = 0;

  hack_data_memory dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .addressM         (addressM),
    .outM             (outM),
    .writeM           (writeM),
    .inM              (inM),
    .kbd_code         (kbd_code),
    .kbd_strobe       (kbd_strobe),
    .scan_valid       (scan_valid),
    .scan_ready       (scan_ready),
    .scan_data        (scan_data),
    .scan_addr        (scan_addr),
    .scan_frame_start (scan_frame_start),
    .addr_fault       (addr_fault)
  );

  always #5 clk = ~clk;

  // Reference model: memory contents with "known" flags, keyboard, fault,
  // and the word currently offered on the scan port.
  logic [15:0] m_ram    [16384];
  bit          m_ram_ok [16384];
  logic [15:0] m_scr    [8192];
  bit          m_scr_ok [8192];
  logic [15:0] m_kbd;
  bit          m_fault;
  bit          m_valid;
  logic [12:0] m_idx;
  logic [15:0] m_data;
  bit          m_data_ok;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 1'b0;
    m_idx   = 13'd0;
    m_kbd   = 16'h0000;
    m_fault = 1'b0;
  endtask

  // One rising edge worth of model behaviour, using the inputs as driven.
  task automatic model_edge();
    if (!reset_n) begin
      model_reset();
    end else begin
      if (!m_valid) begin
        m_data    = m_scr[m_idx];
        m_data_ok = m_scr_ok[m_idx];
        m_valid   = 1'b1;
      end else if (scan_ready) begin
        m_valid = 1'b0;
        m_idx   = m_idx + 13'd1;
      end
      if (kbd_strobe) m_kbd = kbd_code;
      if (writeM) begin
        if (addressM < 15'h4000) begin
          m_ram[addressM]    = outM;
          m_ram_ok[addressM] = 1'b1;
        end else if (addressM < 15'h6000) begin
          m_scr[addressM - 15'h4000]    = outM;
          m_scr_ok[addressM - 15'h4000] = 1'b1;
        end else begin
          m_fault = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [15:0] e;
    bit known;
    chk("scan_valid", {15'd0, scan_valid}, {15'd0, m_valid});
    if (m_valid) begin
      chk("scan_addr", {3'd0, scan_addr}, {3'd0, m_idx});
      if (m_data_ok) chk("scan_data", scan_data, m_data);
    end
    chk("frame_start", {15'd0, scan_frame_start}, {15'd0, (m_valid && m_idx == 13'd0)});
    chk("addr_fault", {15'd0, addr_fault}, {15'd0, m_fault});
    known = 1'b1;
    if (addressM < 15'h4000) begin
      known = m_ram_ok[addressM];
      e = m_ram[addressM];
    end else if (addressM < 15'h6000) begin
      known = m_scr_ok[addressM - 15'h4000];
      e = m_scr[addressM - 15'h4000];
    end else if (addressM == 15'h6000) begin
      e = m_kbd;
    end else begin
      e = 16'h0000;
    end
    if (known) chk("inM", inM, e);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic run_to(input logic [12:0] idx, input int limit);
    int n = 0;
    while (!(m_valid && m_idx == idx) && n < limit) begin
      tick();
      n++;
    end
    chk("run_to_valid", {15'd0, scan_valid}, 16'd1);
    chk("run_to_addr", {3'd0, scan_addr}, {3'd0, idx});
  endtask

  logic [15:0] saved;

  initial begin
    for (int i = 0; i < 16384; i++) m_ram_ok[i] = 1'b0;
    for (int i = 0; i < 8192; i++) m_scr_ok[i] = 1'b0;
    m_data_ok  = 1'b0;
    m_data     = 16'h0000;
    model_reset();
    reset_n    = 1'b0;
    addressM   = 15'h6000;
    outM       = 16'h0000;
    writeM     = 1'b0;
    kbd_code   = 16'h0000;
    kbd_strobe = 1'b0;
    scan_ready = 1'b0;

    // Outputs while held in reset.
    #2;
    chk("rst_valid", {15'd0, scan_valid}, 16'd0);
    chk("rst_data", scan_data, 16'h0000);
    chk("rst_addr", {3'd0, scan_addr}, 16'd0);
    chk("rst_frame", {15'd0, scan_frame_start}, 16'd0);
    chk("rst_fault", {15'd0, addr_fault}, 16'd0);
    chk("rst_kbd", inM, 16'h0000);
    addressM = 15'h7000;
    #1 chk("rst_unmapped", inM, 16'h0000);
    @(negedge clk);
    tick();
    reset_n = 1'b1;

    // Fill the whole screen (word 0/1 get the directed pattern), then RAM 0..63.
    for (int i = 0; i < 8192; i++) begin
      addressM = 15'(15'h4000 + i);
      outM     = (i == 0) ? 16'hAAAA : (i == 1) ? 16'h5555 : 16'($urandom);
      writeM   = 1'b1;
      tick();
    end
    for (int i = 0; i < 64; i++) begin
      addressM = 15'(i);
      outM     = 16'($urandom);
      tick();
    end
    writeM = 1'b0;

    // RAM write/read.
    saved    = m_ram[17];
    addressM = 15'h0010;
    outM     = 16'h1234;
    writeM   = 1'b1;
    tick();
    writeM = 1'b0;
    chk("ram_0010", inM, 16'h1234);
    addressM = 15'h0011;
    #1 chk("ram_0011", inM, saved);

    // Keyboard load and protected write.
    kbd_code   = 16'h0041;
    kbd_strobe = 1'b1;
    addressM   = 15'h6000;
    tick();
    kbd_strobe = 1'b0;
    tick();
    chk("kbd_read", inM, 16'h0041);
    outM   = 16'hFFFF;
    writeM = 1'b1;
    tick();
    writeM = 1'b0;
    chk("kbd_protect", inM, 16'h0041);
    chk("fault_set", {15'd0, addr_fault}, 16'd1);
    addressM = 15'h7000;
    #1 chk("unmapped", inM, 16'h0000);

    // Restart the scan from word 0 with known screen contents.
    @(negedge clk);
    reset_n = 1'b0;
    model_reset();
    tick();
    scan_ready = 1'b1;
    reset_n    = 1'b1;
    tick();
    chk("first_addr", {3'd0, scan_addr}, 16'd0);
    chk("first_data", scan_data, 16'hAAAA);
    chk("first_frame", {15'd0, scan_frame_start}, 16'd1);
    tick();
    tick();
    chk("second_addr", {3'd0, scan_addr}, 16'd1);
    chk("second_data", scan_data, 16'h5555);

    // Backpressure on word 3.
    run_to(13'd3, 20);
    saved      = m_scr[3];
    scan_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", {15'd0, scan_valid}, 16'd1);
      chk("bp_addr", {3'd0, scan_addr}, 16'd3);
      chk("bp_data", scan_data, saved);
    end
    scan_ready = 1'b1;
    tick();
    tick();
    chk("bp_next_addr", {3'd0, scan_addr}, 16'd4);

    // Randomized traffic on every port.
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: addressM = 15'($urandom_range(0, 63));
        4, 5, 6, 7: addressM = 15'(15'h4000 + $urandom_range(0, 8191));
        8:          addressM = 15'h6000;
        default:    addressM = 15'($urandom_range(15'h6001, 15'h7FFF));
      endcase
      outM       = 16'($urandom);
      writeM     = ($urandom_range(0, 2) == 0);
      kbd_strobe = ($urandom_range(0, 7) == 0);
      kbd_code   = 16'($urandom);
      scan_ready = ($urandom_range(0, 1) == 0);
      tick();
    end
    writeM     = 1'b0;
    kbd_strobe = 1'b0;
    scan_ready = 1'b1;
    addressM   = 15'h4000;

    // Wrap 8191 -> 0 with a colliding CPU write on the LOAD edge of word 0.
    run_to(13'd8191, 17000);
    tick();
    saved  = m_scr[0];
    outM   = 16'hBEEF;
    writeM = 1'b1;
    tick();
    writeM = 1'b0;
    chk("wrap_addr", {3'd0, scan_addr}, 16'd0);
    chk("wrap_frame", {15'd0, scan_frame_start}, 16'd1);
    chk("collide_old", scan_data, saved);
    chk("collide_inM", inM, 16'hBEEF);
    run_to(13'd8191, 17000);
    tick();
    tick();
    chk("next_frame_data", scan_data, 16'hBEEF);
    chk("next_frame_start", {15'd0, scan_frame_start}, 16'd1);

    // Reset mid-frame at index 100.
    run_to(13'd100, 400);
    m_fault = 1'b1;
    outM    = 16'h0000;
    addressM = 15'h7FFF;
    writeM  = 1'b1;
    tick();
    writeM = 1'b0;
    chk("fault_pre_reset", {15'd0, addr_fault}, 16'd1);
    #2 reset_n = 1'b0;
    addressM = 15'h6000;
    #1;
    chk("mid_valid", {15'd0, scan_valid}, 16'd0);
    chk("mid_fault", {15'd0, addr_fault}, 16'd0);
    chk("mid_data", scan_data, 16'h0000);
    chk("mid_addr", {3'd0, scan_addr}, 16'd0);
    chk("mid_kbd", inM, 16'h0000);
    model_reset();
    @(negedge clk);
    tick();
    reset_n = 1'b1;
    tick();
    chk("restart_addr", {3'd0, scan_addr}, 16'd0);
    chk("restart_data", scan_data, 16'hBEEF);
    chk("restart_frame", {15'd0, scan_frame_start}, 16'd1);
    addressM = 15'h0010;
    #1 chk("ram_retained", inM, m_ram[16]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
